reg_file_8_16: RTL and testbench

//   LC-3 general-purpose register file R0..R7 (16-bit) plus NZP condition-code register.

---
 rtl/reg_file_8_16_pkg.sv | 21 ++
 rtl/reg_file_8_16_if.sv | 24 ++
 rtl/reg_file_8_16_dec.sv | 12 +
 rtl/reg_file_8_16.sv | 52 +++++
 tb/tb_reg_file_8_16.sv | 140 ++++++++++++++
 5 files changed

// File: rtl/reg_file_8_16_pkg.sv
// Shared constants, types and condition-code helpers for the LC-3 register file.
package reg_file_8_16_pkg;
    localparam int WORD_W   = 16;
    localparam int SEL_W    = 3;
    localparam int NUM_REGS = 1 << SEL_W;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [SEL_W-1:0]  reg_sel_t;
    typedef logic [2:0]        cc_t;

    localparam cc_t CC_N     = 3'b100;
    localparam cc_t CC_Z     = 3'b010;
    localparam cc_t CC_P     = 3'b001;
    localparam cc_t CC_RESET = CC_Z;

    function automatic cc_t cc_of(word_t w);
        if (w[WORD_W-1])  return CC_N;
        else if (w == '0) return CC_Z;
        else              return CC_P;
    endfunction
endpackage

// File: rtl/reg_file_8_16_if.sv
// Datapath-side bundle of the register file: write/cc controls in, read data and status out.
interface reg_file_8_16_if;
    import reg_file_8_16_pkg::*;

    logic                ld_reg;
    reg_sel_t            dr_sel;
    word_t               bus_in;
    logic                ld_cc;
    reg_sel_t            sr1_sel;
    reg_sel_t            sr2_sel;
    word_t               sr1_out;
    word_t               sr2_out;
    cc_t                 nzp;
    logic [NUM_REGS-1:0] wr_onehot;

    modport master (
        output ld_reg, dr_sel, bus_in, ld_cc, sr1_sel, sr2_sel,
        input  sr1_out, sr2_out, nzp, wr_onehot
    );
    modport slave (
        input  ld_reg, dr_sel, bus_in, ld_cc, sr1_sel, sr2_sel,
        output sr1_out, sr2_out, nzp, wr_onehot
    );
endinterface

// File: rtl/reg_file_8_16_dec.sv
// 3->8 destination decoder: one-hot write strobe, all zero when disabled.
module dec_3_8
    import reg_file_8_16_pkg::*;
(
    input  reg_sel_t            sel_i,
    input  logic                en_i,
    output logic [NUM_REGS-1:0] onehot_o
);
    localparam logic [NUM_REGS-1:0] ONE = {{(NUM_REGS-1){1'b0}}, 1'b1};

    assign onehot_o = en_i ? (ONE << sel_i) : '0;
endmodule

// File: rtl/reg_file_8_16.sv
// LC-3 register file R0..R7 with NZP register, two combinational read ports and
// optional same-cycle write forwarding.
module reg_file_8_16
    import reg_file_8_16_pkg::*;
#(
    parameter bit BYPASS = 1'b1
) (
    input  logic          clk,
    input  logic          reset_n,
    reg_file_8_16_if.slave rf
);
    logic [NUM_REGS-1:0]             wr_stb;
    logic [NUM_REGS-1:0][WORD_W-1:0] regs_q, regs_d;
    cc_t                             nzp_q, nzp_d;
    word_t                           sr1_d, sr2_d;

    dec_3_8 u_dec (
        .sel_i    (rf.dr_sel),
        .en_i     (rf.ld_reg),
        .onehot_o (wr_stb)
    );

    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < NUM_REGS; i++)
            if (wr_stb[i]) regs_d[i] = rf.bus_in;
        nzp_d = rf.ld_cc ? cc_of(rf.bus_in) : nzp_q;
    end

    // Reset wins over any write or cc load presented in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            regs_q <= '0;
            nzp_q  <= CC_RESET;
        end else begin
            regs_q <= regs_d;
            nzp_q  <= nzp_d;
        end
    end

    always_comb begin
        sr1_d = regs_q[rf.sr1_sel];
        sr2_d = regs_q[rf.sr2_sel];
        if (BYPASS && rf.ld_reg && (rf.sr1_sel == rf.dr_sel)) sr1_d = rf.bus_in;
        if (BYPASS && rf.ld_reg && (rf.sr2_sel == rf.dr_sel)) sr2_d = rf.bus_in;
    end

    assign rf.sr1_out   = sr1_d;
    assign rf.sr2_out   = sr2_d;
    assign rf.nzp       = nzp_q;
    assign rf.wr_onehot = wr_stb;
endmodule

// File: tb/tb_reg_file_8_16.sv
// Bench for reg_file_8_16: random traffic against an array model, then a directed vector table.
module tb_reg_file_8_16;
    localparam bit BYPASS = 1'b1;

    logic clk = 1'b0;
    logic reset_n;
    reg_file_8_16_if rf ();

    reg_file_8_16 #(.BYPASS(BYPASS)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .rf      (rf.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int rn, ld, dr, bus, cc, s1, s2;
        int e1, e2, eoh, enzp;
    } vec_t;

    vec_t tbl[$];
    int   mregs[8];
    int   mnzp;
    int   nvec = 0;
    int   nmis = 0;

    function automatic int cc_ref(int w);
        if (w == 0)          return 2;
        else if (w >= 32768) return 4;
        else                 return 1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle, compare against the model before the edge, then advance the model.
    task automatic step(input int rn, ld, dr, bus, cc, s1, s2,
                        output int o1, o2, ooh, onzp);
        int e1, e2;
        @(negedge clk);
        reset_n    = rn[0];
        rf.ld_reg  = ld[0];
        rf.dr_sel  = dr[2:0];
        rf.bus_in  = bus[15:0];
        rf.ld_cc   = cc[0];
        rf.sr1_sel = s1[2:0];
        rf.sr2_sel = s2[2:0];
        #1;
        o1 = int'(rf.sr1_out); o2 = int'(rf.sr2_out);
        ooh = int'(rf.wr_onehot); onzp = int'(rf.nzp);
        e1 = (BYPASS && ld != 0 && s1 == dr) ? bus : mregs[s1];
        e2 = (BYPASS && ld != 0 && s2 == dr) ? bus : mregs[s2];
        chk("model_sr1", o1, e1);
        chk("model_sr2", o2, e2);
        chk("model_onehot", ooh, (ld != 0) ? (1 << dr) : 0);
        chk("model_nzp", onzp, mnzp);
        @(posedge clk);
        if (rn == 0) begin
            foreach (mregs[i]) mregs[i] = 0;
            mnzp = 2;
        end else begin
            if (ld != 0) mregs[dr] = bus;
            if (cc != 0) mnzp = cc_ref(bus);
        end
    endtask

    task automatic add(input int rn, ld, dr, bus, cc, s1, s2, e1, e2, eoh, enzp);
        vec_t v;
        v = '{rn, ld, dr, bus, cc, s1, s2, e1, e2, eoh, enzp};
        tbl.push_back(v);
    endtask

    initial begin
        int o1, o2, ooh, onzp;
        int bus;

        reset_n = 1'b0;
        rf.ld_reg = 1'b0; rf.dr_sel = '0; rf.bus_in = '0;
        rf.ld_cc = 1'b0; rf.sr1_sel = '0; rf.sr2_sel = '0;
        repeat (2) @(posedge clk);
        foreach (mregs[i]) mregs[i] = 0;
        mnzp = 2;

        // Randomized traffic with occasional resets and cc edge values.
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 5))
                0:       bus = 0;
                1:       bus = 16'h8000;
                2:       bus = 16'h7FFF;
                default: bus = int'($urandom_range(0, 16'hFFFF));
            endcase
            step(($urandom_range(0, 24) != 0) ? 1 : 0, int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 7)), bus, int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                 o1, o2, ooh, onzp);
        end
        // Reset after random writes, with a write pending that must be dropped.
        step(0, 1, 6, 16'hBEEF, 1, 0, 0, o1, o2, ooh, onzp);

        for (int i = 0; i < 8; i++)
            add(1, 0, 0, 0, 0, i, 7 - i, 0, 0, 0, 2);
        for (int i = 0; i < 8; i++)
            add(1, 1, i, 16'h1111 * i, 0, i, (i + 1) % 8,
                BYPASS ? 16'h1111 * i : 0, 0, 1 << i, 2);
        for (int i = 0; i < 8; i++)
            add(1, 0, 0, 0, 0, i, 7 - i, 16'h1111 * i, 16'h1111 * (7 - i), 0, 2);
        add(1, 1, 3, 16'h00AA, 0, 0, 0, 0, 0, 8, 2);
        add(1, 1, 3, 16'h5555, 0, 3, 3,
            BYPASS ? 16'h5555 : 16'h00AA, BYPASS ? 16'h5555 : 16'h00AA, 8, 2);
        add(1, 0, 3, 0, 0, 3, 3, 16'h5555, 16'h5555, 0, 2);
        add(1, 0, 0, 16'h8000, 1, 0, 1, 0, 16'h1111, 0, 2);
        add(1, 0, 0, 16'h0000, 1, 0, 1, 0, 16'h1111, 0, 4);
        add(1, 0, 0, 16'h7FFF, 1, 0, 1, 0, 16'h1111, 0, 2);
        add(1, 0, 0, 16'h8000, 0, 0, 1, 0, 16'h1111, 0, 1);
        add(1, 0, 0, 16'h0000, 0, 0, 1, 0, 16'h1111, 0, 1);
        add(1, 0, 5, 16'hDEAD, 0, 5, 5, 16'h5555, 16'h5555, 0, 1);
        add(1, 1, 7, 16'hFFFF, 1, 5, 7, 16'h5555, BYPASS ? 16'hFFFF : 16'h7777, 8'h80, 1);
        add(1, 0, 0, 0, 0, 7, 5, 16'hFFFF, 16'h5555, 0, 4);
        add(0, 1, 2, 16'h1234, 0, 2, 7, BYPASS ? 16'h1234 : 16'h2222, 16'hFFFF, 4, 4);
        add(1, 0, 0, 0, 0, 2, 7, 0, 0, 0, 2);

        foreach (tbl[k]) begin
            step(tbl[k].rn, tbl[k].ld, tbl[k].dr, tbl[k].bus, tbl[k].cc,
                 tbl[k].s1, tbl[k].s2, o1, o2, ooh, onzp);
            chk($sformatf("vec%0d_sr1", k), o1, tbl[k].e1);
            chk($sformatf("vec%0d_sr2", k), o2, tbl[k].e2);
            chk($sformatf("vec%0d_onehot", k), ooh, tbl[k].eoh);
            chk($sformatf("vec%0d_nzp", k), onzp, tbl[k].enzp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
